// File: rtl/genetico_serial_eval_if.sv
// Config/start/result bundle between the GA controller (master) and the
// serial chromosome evaluator (slave).
interface genetico_serial_eval_if #(
  parameter int N_IN   = 8,
  parameter int N_LE   = 29,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = 6,
  parameter int CFG_W  = 3 + 2 * SEL_W,
  parameter int ADDR_W = $clog2(N_LE + N_OUT)
);
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [CFG_W-1:0]  cfg_wdata;
  logic              cfg_err;
  logic              start;
  logic [N_IN-1:0]   chrom_in;
  logic              in_ready;
  logic              busy;
  logic [N_OUT-1:0]  chrom_out;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, start, chrom_in, out_ready,
    input  cfg_err, in_ready, busy, chrom_out, out_valid
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, start, chrom_in, out_ready,
    output cfg_err, in_ready, busy, chrom_out, out_valid
  );
endinterface

// File: rtl/genetico_serial_eval.sv
// Serial genetic-circuit evaluator: one logic element per clock over a
// feed-forward node vector, followed by a registered output selection.
module genetico_serial_eval #(
  parameter int N_IN  = 8,
  parameter int N_LE  = 29,
  parameter int N_OUT = 8,
  parameter int SEL_W = 6,
  parameter int CFG_W = 3 + 2 * SEL_W
) (
  input logic                   clk,
  input logic                   rst_n,
  genetico_serial_eval_if.slave bus
);
  localparam int N_NODE = N_IN + N_LE;
  localparam int N_CFG  = N_LE + N_OUT;
  localparam int ADDR_W = $clog2(N_CFG);
  localparam int K_W    = (N_LE > 1) ? $clog2(N_LE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_OUT, S_DONE} state_t;

  state_t              r_state, w_state_next;
  logic [K_W-1:0]      r_k;
  logic [N_NODE-1:0]   r_nodes;
  logic [CFG_W-1:0]    r_le_cfg  [N_LE];
  logic [SEL_W-1:0]    r_out_sel [N_OUT];
  logic [N_OUT-1:0]    r_chrom_out;
  logic                r_out_valid;
  logic                r_cfg_err;

  logic                w_last;
  logic                w_cfg_ok;
  logic                w_cfg_acc;
  logic [2**SEL_W-1:0] w_nodes_ext;
  logic [CFG_W-1:0]    w_cur_cfg;
  logic [2:0]          w_func;
  logic [SEL_W-1:0]    w_sel_a, w_sel_b, w_dst;
  logic [SEL_W:0]      w_limit;
  logic                w_a, w_b, w_le_out;
  logic [N_OUT-1:0]    w_out_vec;

  assign w_last    = (r_k == K_W'(N_LE - 1));
  assign w_cfg_ok  = (bus.cfg_addr < ADDR_W'(N_CFG));
  assign w_cfg_acc = bus.cfg_we && (r_state == S_IDLE) && w_cfg_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start)     w_state_next = S_EVAL;
      S_EVAL:  if (w_last)        w_state_next = S_OUT;
      S_OUT:                      w_state_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
      default:                    w_state_next = S_IDLE;
    endcase
  end

  // Zero-extend so any selector code indexes safely; codes past the last node read 0.
  always_comb begin
    w_nodes_ext              = '0;
    w_nodes_ext[N_NODE-1:0]  = r_nodes;
  end

  assign w_cur_cfg = r_le_cfg[r_k];
  assign w_func    = w_cur_cfg[CFG_W-1 -: 3];
  assign w_sel_b   = w_cur_cfg[2*SEL_W-1 -: SEL_W];
  assign w_sel_a   = w_cur_cfg[SEL_W-1:0];
  assign w_limit   = (SEL_W+1)'(N_IN) + (SEL_W+1)'(r_k);
  assign w_dst     = w_limit[SEL_W-1:0];

  // Nodes at or above the current LE may hold stale values from an earlier run.
  assign w_a = ({1'b0, w_sel_a} < w_limit) && w_nodes_ext[w_sel_a];
  assign w_b = ({1'b0, w_sel_b} < w_limit) && w_nodes_ext[w_sel_b];

  always_comb begin
    w_le_out = 1'b0;
    case (w_func)
      3'd0: w_le_out =   w_a & w_b;
      3'd1: w_le_out =   w_a | w_b;
      3'd2: w_le_out =   w_a ^ w_b;
      3'd3: w_le_out = ~(w_a & w_b);
      3'd4: w_le_out = ~(w_a | w_b);
      3'd5: w_le_out = ~(w_a ^ w_b);
      3'd6: w_le_out =   w_a;
      3'd7: w_le_out =  ~w_a;
      default: w_le_out = 1'b0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_out_mux
      assign w_out_vec[gi] = ({1'b0, r_out_sel[gi]} < (SEL_W+1)'(N_NODE))
                             && w_nodes_ext[r_out_sel[gi]];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LE; i++)  r_le_cfg[i]  <= '0;
      for (int i = 0; i < N_OUT; i++) r_out_sel[i] <= '0;
    end else if (w_cfg_acc) begin
      for (int i = 0; i < N_LE; i++)
        if (bus.cfg_addr == ADDR_W'(i)) r_le_cfg[i] <= bus.cfg_wdata;
      for (int i = 0; i < N_OUT; i++)
        if (bus.cfg_addr == ADDR_W'(N_LE + i)) r_out_sel[i] <= bus.cfg_wdata[SEL_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k         <= '0;
      r_nodes     <= '0;
      r_chrom_out <= '0;
      r_out_valid <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= bus.cfg_we && !((r_state == S_IDLE) && w_cfg_ok);
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_nodes[N_IN-1:0] <= bus.chrom_in;
          r_k               <= '0;
        end
        S_EVAL: begin
          r_nodes[w_dst] <= w_le_out;
          if (!w_last) r_k <= r_k + 1'b1;
        end
        S_OUT: begin
          r_chrom_out <= w_out_vec;
          r_out_valid <= 1'b1;
        end
        S_DONE: if (bus.out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.chrom_out = r_chrom_out;
  assign bus.out_valid = r_out_valid;
  assign bus.cfg_err   = r_cfg_err;
endmodule

// File: tb/tb_genetico_serial_eval.sv
// Scoreboard bench for genetico_serial_eval: a driver issues config writes and
// evaluations, a separate monitor checks each presented result and its latency.
module tb_genetico_serial_eval;
  localparam int N_IN = 8, N_LE = 29, N_OUT = 8, SEL_W = 6;
  localparam int N_CFG = N_LE + N_OUT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  genetico_serial_eval_if #(.N_IN(N_IN), .N_LE(N_LE), .N_OUT(N_OUT), .SEL_W(SEL_W)) bus ();

  genetico_serial_eval #(.N_IN(N_IN), .N_LE(N_LE), .N_OUT(N_OUT), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] exp;
    int         acc;
  } sb_t;
  sb_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference configuration, written only when the bench expects acceptance.
  int m_func [N_LE];
  int m_a    [N_LE];
  int m_b    [N_LE];
  int m_osel [N_OUT];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_LE; i++) begin m_func[i] = 0; m_a[i] = 0; m_b[i] = 0; end
    for (int i = 0; i < N_OUT; i++) m_osel[i] = 0;
  endtask

  task automatic model_write(input int addr, input logic [14:0] d);
    if (addr < N_LE) begin
      m_func[addr] = int'(d[14:12]);
      m_b[addr]    = int'(d[11:6]);
      m_a[addr]    = int'(d[5:0]);
    end else begin
      m_osel[addr - N_LE] = int'(d[5:0]);
    end
  endtask

  // Nodes are filled in order into a fresh zeroed array, so anything not yet
  // computed (or beyond the last node) naturally reads as 0.
  function automatic logic [7:0] model(input logic [7:0] ci);
    logic nd [64];
    logic a, b, f;
    logic [7:0] r;
    for (int i = 0; i < 64; i++) nd[i] = 1'b0;
    for (int i = 0; i < N_IN; i++) nd[i] = ci[i];
    for (int k = 0; k < N_LE; k++) begin
      a = nd[m_a[k]];
      b = nd[m_b[k]];
      case (m_func[k])
        0: f = a & b;
        1: f = a | b;
        2: f = a ^ b;
        3: f = !(a & b);
        4: f = !(a | b);
        5: f = !(a ^ b);
        6: f = a;
        default: f = !a;
      endcase
      nd[N_IN + k] = f;
    end
    for (int j = 0; j < N_OUT; j++) r[j] = nd[m_osel[j]];
    return r;
  endfunction

  function automatic logic [14:0] le_word(input int func, input int sb_, input int sa);
    return {3'(func), 6'(sb_), 6'(sa)};
  endfunction

  task automatic cfg_write(input int addr, input logic [14:0] d);
    logic exp_err;
    @(negedge clk);
    exp_err = bus.busy || (addr >= N_CFG);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 6'(addr);
    bus.cfg_wdata = d;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    chk($sformatf("cfg_err addr=%0d", addr), 32'(bus.cfg_err), 32'(exp_err));
    if (!exp_err) model_write(addr, d);
    @(posedge clk);
    #1;
    chk("cfg_err_one_cycle", 32'(bus.cfg_err), 0);
  endtask

  task automatic start_eval(input logic [7:0] ci, input bit wr = 1'b0,
                            input int addr = 0, input logic [14:0] d = '0);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    bus.chrom_in = ci;
    bus.start = 1'b1;
    if (wr) begin
      bus.cfg_we = 1'b1;
      bus.cfg_addr = 6'(addr);
      bus.cfg_wdata = d;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.cfg_we = 1'b0;
    if (wr) model_write(addr, d);
    sb.push_back('{model(ci), cyc});
    $display("start chrom_in=%02h expect=%02h", ci, model(ci));
    chk("busy_after_accept", 32'(bus.busy), 1);
    chk("in_ready_after_accept", 32'(bus.in_ready), 0);
  endtask

  task automatic finish_eval(input int hold, input bit poke);
    int n = 0;
    logic [7:0] held;
    @(negedge clk);
    while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
    if (!bus.out_valid) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
      sb.delete();
      return;
    end
    held = bus.chrom_out;
    for (int i = 0; i < hold; i++) begin
      chk("hold_chrom_out", 32'(bus.chrom_out), 32'(held));
      chk("hold_out_valid", 32'(bus.out_valid), 1);
      chk("hold_in_ready", 32'(bus.in_ready), 0);
      if (poke) bus.start = (i % 2 == 0);
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("out_valid_after_ack", 32'(bus.out_valid), 0);
    chk("in_ready_after_ack", 32'(bus.in_ready), 1);
  endtask

  task automatic run(input logic [7:0] ci, input int hold = 0, input bit poke = 1'b0);
    start_eval(ci);
    finish_eval(hold, poke);
  endtask

  // Monitor: compare each newly presented result against the scoreboard head.
  initial begin : monitor
    bit seen = 1'b0;
    sb_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && !seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got %02h expected no output", bus.chrom_out);
        end else begin
          e = sb.pop_front();
          chk("result", 32'(bus.chrom_out), 32'(e.exp));
          chk("latency", 32'(cyc - e.acc), 30);
        end
      end
      if (!bus.out_valid) seen = 1'b0;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_wdata = '0;
    bus.start = 1'b0;
    bus.chrom_in = '0;
    bus.out_ready = 1'b0;
    model_reset();
    #23;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 32'(bus.in_ready), 1);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_chrom_out", 32'(bus.chrom_out), 0);
    chk("reset_cfg_err", 32'(bus.cfg_err), 0);

    // Default chromosome: every output follows input bit 0.
    run(8'hA5);
    run(8'hA4);

    // XOR path
    cfg_write(0, le_word(2, 1, 0));
    cfg_write(N_LE + 0, 15'd8);
    cfg_write(N_LE + 1, 15'd1);
    for (int j = 2; j < N_OUT; j++) cfg_write(N_LE + j, 15'd37);
    run(8'h01);
    run(8'h03);

    // Feed-forward masking and chaining
    cfg_write(0, le_word(1, 10, 9));
    cfg_write(1, le_word(6, 0, 8));
    cfg_write(N_LE + 1, 15'd9);
    run(8'hFF);
    cfg_write(0, le_word(7, 0, 2));
    run(8'h00, 5, 1'b1);

    // Rejected writes: busy, then out-of-range address
    start_eval(8'h00);
    cfg_write(0, le_word(0, 0, 0));
    finish_eval(0, 1'b0);
    run(8'h00);
    cfg_write(37, le_word(0, 0, 0));
    cfg_write(63, le_word(4, 1, 1));
    run(8'h00);

    // Write and start in the same cycle
    start_eval(8'h00, 1'b1, 0, le_word(6, 0, 2));
    finish_eval(1, 1'b0);

    // Random chromosomes and inputs
    for (int i = 0; i < 24; i++) begin
      int addr;
      logic [14:0] d;
      addr = int'($urandom_range(0, N_CFG - 1));
      if (addr < N_LE)
        d = le_word(int'($urandom_range(0, 7)), int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 63)));
      else
        d = 15'($urandom_range(0, 63));
      cfg_write(addr, d);
    end
    for (int i = 0; i < 8; i++) run(8'($urandom), int'($urandom_range(0, 3)), 1'b1);
    cfg_write(N_LE + 0, 15'd0);
    run(8'h01);

    // Mid-run reset at k=12
    start_eval(8'h5A);
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(bus.busy), 0);
    chk("midreset_out_valid", 32'(bus.out_valid), 0);
    chk("midreset_chrom_out", 32'(bus.chrom_out), 0);
    chk("midreset_in_ready", 32'(bus.in_ready), 1);
    sb.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(8'hA5);
    run(8'hA4);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
